// File: rtl/cuenta_bits_param_if.sv
// Start/fin handshake bundle for cuenta_bits_param.
// The master drives the operand and the request; the slave returns the count and status.
interface cuenta_bits_param_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned CW = $clog2(N + 1);

    logic [N-1:0]  Valor;
    logic          modo;
    logic          start;
    logic [CW-1:0] Cuenta;
    logic          fin;
    logic          busy;

    modport master (
        output Valor,
        output modo,
        output start,
        input  Cuenta,
        input  fin,
        input  busy
    );

    modport slave (
        input  Valor,
        input  modo,
        input  start,
        output Cuenta,
        output fin,
        output busy
    );
endinterface

// File: rtl/cuenta_bits_param.sv
// Multicycle ones/zeros counter: shifts the loaded operand right and accumulates the LSB,
// stopping as soon as the remaining bits are all zero.
module cuenta_bits_param #(
    parameter int unsigned N = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    cuenta_bits_param_if.slave bus_io
);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic {
        StIdle,
        StCuenta
    } state_e;

    state_e        state_q;
    logic [N-1:0]  q_q;
    logic [CW-1:0] a_q;
    logic          fin_q;
    logic          busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            a_q     <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Accepted even while fin is high, so a done result can be restarted.
                    if (bus_io.start) begin
                        q_q     <= bus_io.modo ? ~bus_io.Valor : bus_io.Valor;
                        a_q     <= '0;
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StCuenta;
                    end
                end
                StCuenta: begin
                    if (q_q != '0) begin
                        a_q <= a_q + CW'(q_q[0]);
                        q_q <= q_q >> 1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        fin_q   <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.Cuenta = a_q;
    assign bus_io.fin    = fin_q;
    assign bus_io.busy   = busy_q;
endmodule

// File: tb/tb_cuenta_bits_param.sv
// Bench for cuenta_bits_param: N=8 and N=3 instances checked against a popcount/latency model.
module tb_cuenta_bits_param;
    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    cuenta_bits_param_if #(.N(8)) bus8 ();
    cuenta_bits_param_if #(.N(3)) bus3 ();

    cuenta_bits_param #(.N(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (bus8.slave)
    );

    cuenta_bits_param #(.N(3)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (bus3.slave)
    );

    // Expected count: number of operand bits equal to (modo ? 0 : 1).
    function automatic int ref_count(input logic [31:0] v, input int w, input bit m);
        int c = 0;
        for (int i = 0; i < w; i++) if ((v[i] ^ m) == 1'b1) c++;
        return c;
    endfunction

    // Edges after the start edge until fin: highest set bit of the loaded word + 2, or 1 if empty.
    function automatic int ref_lat(input logic [31:0] v, input int w, input bit m);
        int h = -1;
        for (int i = 0; i < w; i++) if ((v[i] ^ m) == 1'b1) h = i;
        return (h < 0) ? 1 : h + 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count8(input logic [7:0] v, input bit m, input bit scramble, input string tag);
        int k = 0;
        int exp_c = ref_count({24'h0, v}, 8, m);
        int exp_l = ref_lat({24'h0, v}, 8, m);
        bus8.Valor = v;
        bus8.modo  = m;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tests++;
        if (bus8.busy !== 1'b1 || bus8.fin !== 1'b0) begin
            fails++;
            $display("FAIL %s accept: busy=%b fin=%b required busy=1 fin=0", tag, bus8.busy, bus8.fin);
        end
        do begin
            if (scramble) begin
                bus8.Valor = 8'($urandom);
                bus8.modo  = 1'($urandom);
            end
            tick();
            k++;
        end while (bus8.fin !== 1'b1 && k < 20);
        tests++;
        if (k !== exp_l) begin
            fails++;
            $display("FAIL %s latency: got %0d edges required %0d", tag, k, exp_l);
        end
        tests++;
        if (bus8.Cuenta !== exp_c || bus8.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s result: Cuenta=%0d busy=%b required Cuenta=%0d busy=0",
                     tag, bus8.Cuenta, bus8.busy, exp_c);
        end
    endtask

    task automatic count3(input logic [2:0] v, input bit m, input string tag);
        int k = 0;
        int exp_c = ref_count({29'h0, v}, 3, m);
        int exp_l = ref_lat({29'h0, v}, 3, m);
        bus3.Valor = v;
        bus3.modo  = m;
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        do begin
            tick();
            k++;
        end while (bus3.fin !== 1'b1 && k < 10);
        tests++;
        if (k !== exp_l || bus3.Cuenta !== exp_c || bus3.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: edges=%0d Cuenta=%0d busy=%b required edges=%0d Cuenta=%0d busy=0",
                     tag, k, bus3.Cuenta, bus3.busy, exp_l, exp_c);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        tests++;
        if (bus8.Cuenta !== 0 || bus8.fin !== 1'b0 || bus8.busy !== 1'b0 ||
            bus3.Cuenta !== 0 || bus3.fin !== 1'b0 || bus3.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset: Cuenta8=%0d fin8=%b busy8=%b Cuenta3=%0d required all zero",
                     bus8.Cuenta, bus8.fin, bus8.busy, bus3.Cuenta);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_ones();
        count8(8'b1011_0110, 1'b0, 1'b1, "ones");
    endtask

    task automatic test_zeros();
        count8(8'b1011_0110, 1'b1, 1'b1, "zeros");
    endtask

    task automatic test_zero_operand();
        count8(8'h00, 1'b0, 1'b0, "zero_ones");
        count8(8'h00, 1'b1, 1'b0, "zero_zeros_full");
    endtask

    task automatic test_idle_hold();
        logic [3:0] held = bus8.Cuenta;
        for (int i = 0; i < 4; i++) begin
            bus8.Valor = 8'($urandom);
            bus8.modo  = 1'($urandom);
            tick();
        end
        tests++;
        if (bus8.fin !== 1'b1 || bus8.Cuenta !== 4'd8 || bus8.busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_hold: fin=%b Cuenta=%0d busy=%b required fin=1 Cuenta=%0d busy=0",
                     bus8.fin, bus8.Cuenta, bus8.busy, held);
        end
    endtask

    task automatic test_hold_start();
        int k = 0;
        bus8.Valor = 8'hFF;
        bus8.modo  = 1'b0;
        bus8.start = 1'b1;
        tick();
        bus8.Valor = 8'h01;
        do begin
            tick();
            k++;
        end while (bus8.fin !== 1'b1 && k < 20);
        tests++;
        if (k !== 9 || bus8.Cuenta !== 4'd8) begin
            fails++;
            $display("FAIL hold_first: edges=%0d Cuenta=%0d required edges=9 Cuenta=8", k, bus8.Cuenta);
        end
        tick();
        bus8.start = 1'b0;
        tests++;
        if (bus8.fin !== 1'b0 || bus8.busy !== 1'b1) begin
            fails++;
            $display("FAIL hold_restart: fin=%b busy=%b required fin=0 busy=1", bus8.fin, bus8.busy);
        end
        k = 0;
        do begin
            tick();
            k++;
        end while (bus8.fin !== 1'b1 && k < 20);
        tests++;
        if (k !== 2 || bus8.Cuenta !== 4'd1) begin
            fails++;
            $display("FAIL hold_second: edges=%0d Cuenta=%0d required edges=2 Cuenta=1", k, bus8.Cuenta);
        end
    endtask

    task automatic test_abort(input logic [7:0] v, input int edges, input string tag);
        bus8.Valor = v;
        bus8.modo  = 1'b0;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        for (int i = 0; i < edges; i++) tick();
        #1;
        reset_n = 1'b0;
        #1;
        tests++;
        if (bus8.Cuenta !== 0 || bus8.fin !== 1'b0 || bus8.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: Cuenta=%0d fin=%b busy=%b required 0 0 0",
                     tag, bus8.Cuenta, bus8.fin, bus8.busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        count8(8'h03, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_n3();
        count3(3'b111, 1'b0, "n3_ones");
        count3(3'b010, 1'b1, "n3_zeros");
        for (int i = 0; i < 10; i++) count3(3'($urandom), 1'($urandom), "n3_random");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) count8(8'($urandom), 1'($urandom), 1'b1, "random");
    endtask

    initial begin
        bus8.Valor = '0;
        bus8.modo  = 1'b0;
        bus8.start = 1'b0;
        bus3.Valor = '0;
        bus3.modo  = 1'b0;
        bus3.start = 1'b0;
        test_reset();
        test_ones();
        test_zeros();
        test_zero_operand();
        test_idle_hold();
        test_hold_start();
        test_abort(8'hF0, 3, "abort_early");
        test_abort(8'hFF, 6, "abort_mid");
        test_n3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cuenta_bits_param.md
Name: cuenta_bits_param

Overview:
Multicycle bit counter. It counts the ones or the zeros in an N-bit operand using a shift register, an accumulator and a small control FSM. It is the parametrised successor of the fixed 3-bit ones counter. Additions over that counter: configurable width, a count-zeros mode, early termination once the remaining bits are all zero, a busy flag, and restart-while-done. It sits as a datapath peripheral driven by a start/fin handshake.

Parameters:
N, 8, operand width in bits; legal range 2..32.
CW, $clog2(N+1), result width (localparam, derived from N, not overridable).

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
Valor  input  N  operand, sampled only on the accepting start edge.
modo  input  1  0 = count ones, 1 = count zeros; sampled with Valor.
start  input  1  request; level-sampled on each rising edge.
Cuenta  output  CW  accumulator value; valid when fin=1.
fin  output  1  completion flag (level).
busy  output  1  high while a count is in progress.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, Q=0, A=0, Cuenta=0, fin=0, busy=0. Reset asserted mid-count aborts immediately; no partial result is retained.
- Registers: Q, N-bit shift register; A, CW-bit accumulator; state is one of {IDLE, CUENTA}.
- IDLE, start=1 at an edge:
  - Q <= modo ? ~Valor : Valor; A <= 0; fin <= 0; busy <= 1; state <= CUENTA.
  - This applies whether or not fin is currently 1 (restart from done).
- IDLE, start=0: hold everything; fin and Cuenta keep their last values.
- CUENTA, Q != 0 at an edge: A <= A + Q[0]; Q <= Q >> 1 (logical shift, zero fill).
- CUENTA, Q == 0 at an edge: state <= IDLE; busy <= 0; fin <= 1; A unchanged.
- start is ignored while in CUENTA; Valor and modo may change freely during a count.
- Cuenta = A combinationally, so intermediate values are visible but are defined only when fin=1.
- Latency, counting the accepting start edge as edge 0:
  - fin and busy=0 appear after edge h+2, where h = index of the highest set bit of the loaded Q.
  - If the loaded Q is 0, fin appears after edge 1.
  - Worst case is N+1 edges after the start edge.
- Width: A never overflows, since the maximum count is N and N ≤ 2^CW−1. No saturation logic is required.
- fin stays 1 until the next accepted start or reset. busy and fin are never both 1.

Test Plan:
1. N=8, modo=0, Valor=8'b1011_0110, start pulse one cycle -> busy=1 from edge 0; fin=1, busy=0 after edge 9; Cuenta=5.
2. N=8, modo=1, same Valor (loaded Q=8'b0100_1001, h=6) -> fin after edge 8, Cuenta=3.
3. N=8, Valor=8'h00: modo=0 -> fin after edge 1, Cuenta=0; modo=1 -> fin after edge 9, Cuenta=8 (no overflow, CW=4).
4. N=8, Valor=8'hFF modo=0, then hold start=1 and change Valor to 8'h01 during the count -> Cuenta=8 at fin. Because start is still high, a new count of 8'h01 begins on the edge after fin: fin drops, and it ends with Cuenta=1.
5. N=8, Valor=8'hF0 modo=0, deassert reset_n asynchronously after edge 3 -> Cuenta=0, fin=0, busy=0 immediately. After release, a new start with Valor=8'h03 -> Cuenta=2 after edge 3.
6. N=3 instance (CW=2), Valor=3'b111 modo=0 -> fin after edge 4, Cuenta=3; then Valor=3'b010 modo=1 -> Cuenta=2.
